// File: rtl/shapool_pkg.sv
// -----------------------------------------------------------------------------
// shapool_pkg
// Shared definitions for the hashing-pool result transmitter: result frame
// width, status-byte bit positions and the transmitter state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package shapool_pkg;

    localparam int FRAME_WIDTH   = 40;
    localparam int STATUS_VALID  = 7;
    localparam int STATUS_OVF    = 6;
    localparam int STATUS_NOFLAG = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

endpackage

// File: rtl/shapool_prio_enc.sv
// -----------------------------------------------------------------------------
// shapool_prio_enc
// Combinational lowest-set-bit encoder used to turn the pool's per-unit
// match flags into the index of the winning unit.
// Ports:
//   flags_i  [POOL_SIZE-1:0]  per-unit match flags
//   index_o  [IDX_W-1:0]      index of the lowest set flag (0 when none set)
//   none_o                    high when no flag is set
// -----------------------------------------------------------------------------
module shapool_prio_enc #(
    parameter int POOL_SIZE = 2,
    parameter int IDX_W     = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1
) (
    input  logic [POOL_SIZE-1:0] flags_i,
    output logic [IDX_W-1:0]     index_o,
    output logic                 none_o
);

    // NOTE: every output gets a default before the loop so no path through
    // the block leaves a value unassigned, which would infer a latch.
    always_comb begin
        index_o = '0;
        none_o  = 1'b1;
        // Scan from the top down so the lowest set bit is the last writer.
        for (int i = POOL_SIZE - 1; i >= 0; i--) begin
            if (flags_i[i]) begin
                index_o = IDX_W'(i);
                none_o  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/shapool_result_tx.sv
// -----------------------------------------------------------------------------
// shapool_result_tx
// Captures the first success from the hashing pool, folds the winning unit
// index into the nonce upper bits, freezes the pool and shifts a 40-bit
// {status, nonce} frame out MSB first on host-paced strobes.
// Ports:
//   clk             system clock
//   reset           asynchronous, active-high reset
//   success_in      single-cycle success strobe from the pool
//   nonce_in[31:0]  pool nonce (upper POOL_SIZE_LOG2 bits are zero)
//   match_flags_in  per-unit match flags, valid with success_in
//   rd_start        host strobe: load the frame and begin readout
//   shift_en        host strobe: advance one bit
//   bit_out         current frame bit, MSB first
//   result_valid    a result is held
//   halt_out        freeze request to the pool
//   busy            readout in progress
//   done            one-cycle pulse at the end of the frame
// -----------------------------------------------------------------------------
module shapool_result_tx
    import shapool_pkg::*;
#(
    parameter int POOL_SIZE      = 2,
    parameter int POOL_SIZE_LOG2 = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 success_in,
    input  logic [31:0]          nonce_in,
    input  logic [POOL_SIZE-1:0] match_flags_in,
    input  logic                 rd_start,
    input  logic                 shift_en,
    output logic                 bit_out,
    output logic                 result_valid,
    output logic                 halt_out,
    output logic                 busy,
    output logic                 done
);

    localparam logic [5:0] LAST_BIT = 6'(FRAME_WIDTH - 1);

    state_t                   state_q, state_d;
    logic [FRAME_WIDTH-1:0]   sr_q, sr_d;
    logic [5:0]               cnt_q, cnt_d;
    logic [31:0]              nonce_q, nonce_d;
    logic                     valid_q, valid_d;
    logic                     ovf_q, ovf_d;
    logic                     noflag_q, noflag_d;
    logic                     pend_ovf_q, pend_ovf_d;
    logic                     done_q, done_d;

    logic [POOL_SIZE_LOG2-1:0] win_idx;
    logic                      win_none;
    logic [31:0]               captured_nonce;
    logic [FRAME_WIDTH-1:0]    frame;

    shapool_prio_enc #(
        .POOL_SIZE (POOL_SIZE),
        .IDX_W     (POOL_SIZE_LOG2)
    ) u_prio_enc (
        .flags_i (match_flags_in),
        .index_o (win_idx),
        .none_o  (win_none)
    );

    // The pool leaves the top bits zero; the winner index fills them.
    assign captured_nonce = {win_idx, nonce_in[31-POOL_SIZE_LOG2:0]};

    // A success arriving on the same edge as rd_start in HOLD still marks
    // the frame being loaded as overflowed.
    assign frame = {valid_q, ovf_q | success_in, noflag_q, 5'b0, nonce_q};

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        nonce_d    = nonce_q;
        valid_d    = valid_q;
        ovf_d      = ovf_q;
        noflag_d   = noflag_q;
        pend_ovf_d = pend_ovf_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (success_in) begin
                    nonce_d    = captured_nonce;
                    valid_d    = 1'b1;
                    ovf_d      = pend_ovf_q;
                    noflag_d   = win_none;
                    pend_ovf_d = 1'b0;
                    state_d    = HOLD;
                end else if (rd_start) begin
                    // Empty read: the host still gets a well-formed frame.
                    sr_d    = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            HOLD: begin
                if (success_in) begin
                    ovf_d = 1'b1;
                end
                if (rd_start) begin
                    sr_d    = frame;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (success_in) begin
                    pend_ovf_d = 1'b1;
                end
                if (shift_en) begin
                    if (cnt_q == LAST_BIT) begin
                        done_d     = 1'b1;
                        valid_d    = 1'b0;
                        ovf_d      = 1'b0;
                        noflag_d   = 1'b0;
                        pend_ovf_d = 1'b0;
                        sr_d       = '0;
                        cnt_d      = '0;
                        state_d    = IDLE;
                    end else begin
                        sr_d  = {sr_q[FRAME_WIDTH-2:0], 1'b0};
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            nonce_q    <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            noflag_q   <= 1'b0;
            pend_ovf_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            nonce_q    <= nonce_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            noflag_q   <= noflag_d;
            pend_ovf_q <= pend_ovf_d;
            done_q     <= done_d;
        end
    end

    assign busy         = (state_q == SHIFT);
    assign bit_out      = busy & sr_q[FRAME_WIDTH-1];
    assign result_valid = valid_q;
    assign done         = done_q;
    // The pool only needs freezing while a real result is outstanding; an
    // empty readout (no captured result) leaves the pool running.
    assign halt_out     = (state_q == HOLD) | (busy & valid_q);

endmodule
